dsss_tx_serializer: RTL and testbench
=====================================

# dsss_tx_serializer

Byte-to-bit serializer that feeds the `data_in` bit of the CDMA/DSSS transmitter. Software pushes bytes through the same 32-bit register bus used by the DSSS IP into an internal FIFO. The block shifts each byte out one bit at a time and holds every bit for exactly one spreading-code period (`CODE_LEN` clocks), so that the transmitter spreads one full code per data bit. It also provides status and a level interrupt for firmware flow control.

## Interface
- `CODE_LEN`, 6: clocks per data bit; must equal the spreading-code length; legal range ≥ 2.
- `FIFO_DEPTH`, 8: byte FIFO depth; power of 2, 2..16.
- `IDLE_BIT`, 1'b0: value driven on `data_out` when not transmitting.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `waddr` in 32: write address; only `[7:0]` is decoded.
- `wdata` in 32: write data.
- `wstrb` in 4: byte write strobes.
- `wen` in 1: write enable.
- `raddr` in 32: read address; only `[7:0]` is decoded.
- `ren` in 1: read enable.
- `rdata` out 32: read data; combinational; 0 when `ren`=0 or the address is unmapped.
- `data_out` out 1: serial bit to the transmitter `data_in`; registered.
- `bit_strobe` out 1: one-cycle pulse in the first clock of each transmitted bit.
- `busy` out 1: high while a byte is being shifted.
- `irq_empty` out 1: level interrupt = enable & FIFO empty & !busy.

## Operation
Register map:
- 0x00 CTRL (R/W, `wstrb[0]`):
  - bit0 `enable`.
  - bit1 `flush`: write 1; self-clearing; always reads 0.
  - bit2 `msb_first`.
- 0x04 DATA (W, `wstrb[0]`): pushes `wdata[7:0]`. Reads return 0.
- 0x08 STATUS (R):
  - bit0 empty; bit1 full; bit2 busy.
  - bits[7:4] level, 0..FIFO_DEPTH.
  - bit8 overflow, sticky. Writing 1 to bit8 (`wstrb[1]`) clears it.

FIFO:
- A push when full is dropped and sets overflow. The full check uses the start-of-cycle state, so a push is dropped even if a pop occurs in the same cycle.
- A push when not full is accepted even if a pop occurs in the same cycle; level is unchanged in that case.

FSM states: IDLE, SHIFT.
- IDLE:
  - `data_out`=`IDLE_BIT`, `busy`=0.
  - If enable & !empty: pop the head byte into the shift register, set bit_idx=0 and chip_cnt=0, go to SHIFT.
- SHIFT:
  - `data_out` = bit `bit_idx` of the byte (LSB-first), or bit `7-bit_idx` if `msb_first`.
  - chip_cnt counts 0..CODE_LEN-1.
  - At chip_cnt=CODE_LEN-1:
    - If bit_idx<7: increment bit_idx and reset chip_cnt.
    - If bit_idx=7 and enable & !empty: pop the next byte with no gap, restart bit_idx and chip_cnt, stay in SHIFT.
    - Otherwise: go to IDLE.
  - `msb_first` is sampled at byte load; changing it mid-byte does not affect the current byte.
- Enable cleared mid-byte: the current byte completes, then the FSM goes to IDLE. Remaining FIFO contents are kept.
- Flush: empties the FIFO and aborts any byte in progress; the FSM goes to IDLE. Overflow is not cleared. Flush has priority over a DATA push in the same cycle (that push is discarded without setting overflow).
- Reset values:
  - FIFO empty, level 0, overflow 0, enable 0, `msb_first` 0, state IDLE.
  - `data_out`=`IDLE_BIT`, `bit_strobe`=0, `busy`=0, `irq_empty`=0.
- Reset in the middle of a byte takes effect at the next edge; no further bits of that byte are emitted.

## Timing
- DATA write sampled at edge T with the FSM in IDLE and enabled: the FIFO becomes non-empty after T; the FSM loads at edge T+1. The first bit is on `data_out` with `bit_strobe`=1 and `busy`=1 in the cycle after T+1, i.e. 2 cycles after the write.
- Each bit is held for exactly `CODE_LEN` cycles. A byte takes 8·CODE_LEN cycles. Back-to-back bytes have zero idle cycles between them.
- `bit_strobe` period is `CODE_LEN` during continuous transmission.
- `busy` falls and `data_out` returns to `IDLE_BIT` in the cycle after the last chip of the last bit.
- Register writes take effect at the sampling edge. STATUS reflects registered state, with no combinational path from `wdata`.

## Test plan
- **Single byte:** reset, CTRL=0x1, DATA=0xA5, CODE_LEN=6 → `data_out` = 1,0,1,0,0,1,0,1, each held 6 cycles; 8 `bit_strobe` pulses spaced 6 cycles apart; `busy` high for 48 cycles; then `irq_empty`=1.
- **MSB-first, back-to-back:** CTRL=0x5, DATA=0x81 then 0x3C → bits 1,0,0,0,0,0,0,1,0,0,1,1,1,1,0,0 with no gap; `busy` high for 96 cycles continuously.
- **Overflow:** with enable=0, push 9 bytes → STATUS full=1, level=8, overflow=1. Write 0x100 to STATUS → overflow=0 and level still 8.
- **Enable drop:** push 0xFF and 0x00, clear enable during bit 3 of the first byte → first byte completes, `data_out` returns to `IDLE_BIT`, level=1, `busy`=0.
- **Flush:** flush during bit 5 of a byte with 3 bytes queued → next cycle `data_out`=`IDLE_BIT`, `busy`=0, level=0, and the CTRL flush bit reads 0.
- **Reset mid-byte:** assert `rst` mid-byte → all outputs at reset values the next cycle; no `bit_strobe` until new data is written and the block is re-enabled.

Source files
------------

// File: rtl/dsss_tx_serializer.sv
// dsss_tx_serializer: byte FIFO + bit serializer feeding the DSSS transmitter
// data_in. Each data bit is held for CODE_LEN clocks (one spreading-code period).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   waddr/wdata/wstrb/wen   register write bus (addr[7:0] decoded)
//   raddr/ren/rdata   register read bus, rdata combinational
//   data_out          serial bit to transmitter (registered)
//   bit_strobe        pulse in the first clock of each transmitted bit
//   busy              high while a byte is being shifted
//   irq_empty         level irq: enable & FIFO empty & !busy
module dsss_tx_serializer #(
  parameter int unsigned CODE_LEN   = 6,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic        IDLE_BIT   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wen,
  input  logic [31:0] raddr,
  input  logic        ren,
  output logic [31:0] rdata,
  output logic        data_out,
  output logic        bit_strobe,
  output logic        busy,
  output logic        irq_empty
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam logic [CW-1:0] CHIP_LAST = CW'(CODE_LEN - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;

  state_t       r_state, w_state_nxt;
  logic [7:0]   r_fifo [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [LW-1:0] r_level, w_level_nxt;
  logic         r_overflow, r_enable, r_msb_first;
  logic [7:0]   r_shreg, w_shreg_nxt;
  logic         r_msb_lat, w_msb_lat_nxt;
  logic [2:0]   r_bit_idx, w_bit_nxt;
  logic [CW-1:0] r_chip_cnt, w_chip_nxt;
  logic         r_data_out, r_bit_strobe, r_busy, r_irq;
  logic         w_data_nxt, w_strobe_nxt, w_busy_nxt, w_irq_nxt;
  logic         w_wr_ctrl, w_wr_data, w_wr_stat, w_flush;
  logic         w_empty, w_full, w_push_ok, w_pop, w_enable_nxt;
  logic [31:0]  w_rdata;
  logic         w_unused;

  // Write decode; flush is a self-clearing pulse acting at the write edge
  assign w_wr_ctrl    = wen && (waddr[7:0] == 8'h00) && wstrb[0];
  assign w_wr_data    = wen && (waddr[7:0] == 8'h04) && wstrb[0];
  assign w_wr_stat    = wen && (waddr[7:0] == 8'h08) && wstrb[1];
  assign w_flush      = w_wr_ctrl && wdata[1];
  assign w_enable_nxt = w_wr_ctrl ? wdata[0] : r_enable;

  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == LW'(FIFO_DEPTH));
  // Full is judged on start-of-cycle level, so a same-cycle pop never frees a slot
  assign w_push_ok = w_wr_data && !w_full && !w_flush;

  assign w_unused = ^{waddr[31:8], raddr[31:8], wdata[31:9], wstrb[3:2]};

  // Control register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_enable    <= 1'b0;
      r_msb_first <= 1'b0;
    end else if (w_wr_ctrl) begin
      r_enable    <= wdata[0];
      r_msb_first <= wdata[2];
    end
  end

  // Sticky overflow; a push discarded by flush does not count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_wr_data && w_full && !w_flush) begin
      r_overflow <= 1'b1;
    end else if (w_wr_stat && wdata[8]) begin
      r_overflow <= 1'b0;
    end
  end

  // FIFO storage (no reset needed, validity tracked by level)
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_fifo[r_wptr] <= wdata[7:0];
    end
  end

  always_comb begin
    w_level_nxt = r_level;
    if (w_flush) begin
      w_level_nxt = '0;
    end else begin
      case ({w_push_ok, w_pop})
        2'b10:   w_level_nxt = r_level + LW'(1);
        2'b01:   w_level_nxt = r_level - LW'(1);
        default: w_level_nxt = r_level;
      endcase
    end
  end

  // FIFO pointers and level
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      r_level <= w_level_nxt;
      if (w_flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push_ok) r_wptr <= r_wptr + AW'(1);
        if (w_pop)     r_rptr <= r_rptr + AW'(1);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state and shift datapath next values
  always_comb begin
    w_state_nxt   = r_state;
    w_pop         = 1'b0;
    w_shreg_nxt   = r_shreg;
    w_msb_lat_nxt = r_msb_lat;
    w_bit_nxt     = r_bit_idx;
    w_chip_nxt    = r_chip_cnt;
    case (r_state)
      ST_IDLE: begin
        if (r_enable && !w_empty) begin
          w_pop         = 1'b1;
          w_state_nxt   = ST_SHIFT;
          w_shreg_nxt   = r_fifo[r_rptr];
          w_msb_lat_nxt = r_msb_first;
          w_bit_nxt     = 3'd0;
          w_chip_nxt    = '0;
        end
      end
      ST_SHIFT: begin
        if (r_chip_cnt == CHIP_LAST) begin
          if (r_bit_idx != 3'd7) begin
            w_bit_nxt  = r_bit_idx + 3'd1;
            w_chip_nxt = '0;
          end else if (r_enable && !w_empty) begin
            // Gapless reload of the next byte
            w_pop         = 1'b1;
            w_shreg_nxt   = r_fifo[r_rptr];
            w_msb_lat_nxt = r_msb_first;
            w_bit_nxt     = 3'd0;
            w_chip_nxt    = '0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_chip_nxt = r_chip_cnt + CW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Flush aborts the current byte and suppresses any load this cycle
    if (w_flush) begin
      w_state_nxt = ST_IDLE;
      w_pop       = 1'b0;
    end
  end

  // Shift datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg    <= '0;
      r_msb_lat  <= 1'b0;
      r_bit_idx  <= '0;
      r_chip_cnt <= '0;
    end else begin
      r_shreg    <= w_shreg_nxt;
      r_msb_lat  <= w_msb_lat_nxt;
      r_bit_idx  <= w_bit_nxt;
      r_chip_cnt <= w_chip_nxt;
    end
  end

  // Output decode from next-cycle state so outputs land with the state they describe
  always_comb begin
    w_busy_nxt   = (w_state_nxt == ST_SHIFT);
    w_strobe_nxt = w_busy_nxt && (w_chip_nxt == '0);
    w_data_nxt   = IDLE_BIT;
    if (w_busy_nxt) begin
      w_data_nxt = w_msb_lat_nxt ? w_shreg_nxt[3'(3'd7 - w_bit_nxt)] : w_shreg_nxt[w_bit_nxt];
    end
    w_irq_nxt = w_enable_nxt && (w_level_nxt == '0) && !w_busy_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_out   <= IDLE_BIT;
      r_bit_strobe <= 1'b0;
      r_busy       <= 1'b0;
      r_irq        <= 1'b0;
    end else begin
      r_data_out   <= w_data_nxt;
      r_bit_strobe <= w_strobe_nxt;
      r_busy       <= w_busy_nxt;
      r_irq        <= w_irq_nxt;
    end
  end

  // Read mux; level field is 4 bits wide (full bit disambiguates depth 16)
  always_comb begin
    w_rdata = '0;
    if (ren) begin
      case (raddr[7:0])
        8'h00:   w_rdata = {29'd0, r_msb_first, 1'b0, r_enable};
        8'h08:   w_rdata = {23'd0, r_overflow, 4'(r_level), 1'b0, r_busy, w_full, w_empty};
        default: w_rdata = '0;
      endcase
    end
  end

  assign rdata      = w_rdata;
  assign data_out   = r_data_out;
  assign bit_strobe = r_bit_strobe;
  assign busy       = r_busy;
  assign irq_empty  = r_irq;

endmodule

// File: tb/tb_dsss_tx_serializer.sv
// Testbench for dsss_tx_serializer: expected bit sequences are queued at stimulus
// time; a negedge monitor pops one per bit_strobe and checks value, hold and period.
module tb_dsss_tx_serializer;

  localparam int unsigned CODE_LEN = 6;
  localparam logic IDLE_BIT = 1'b0;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] waddr, wdata, raddr, rdata;
  logic [3:0]  wstrb;
  logic        wen, ren;
  logic        data_out, bit_strobe, busy, irq_empty;

  int checks   = 0;
  int failures = 0;

  bit exp_q[$];
  int strobe_cnt = 0;
  int hold = 0;
  bit prev_busy = 1'b0;
  bit cur_bit = 1'b0;

  dsss_tx_serializer #(.CODE_LEN(CODE_LEN), .FIFO_DEPTH(8), .IDLE_BIT(IDLE_BIT)) dut (
    .clk(clk), .rst(rst), .waddr(waddr), .wdata(wdata), .wstrb(wstrb), .wen(wen),
    .raddr(raddr), .ren(ren), .rdata(rdata), .data_out(data_out),
    .bit_strobe(bit_strobe), .busy(busy), .irq_empty(irq_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    waddr = {24'd0, a}; wdata = d; wstrb = s; wen = 1'b1;
    @(negedge clk);
    wen = 1'b0; wstrb = 4'd0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    raddr = {24'd0, a}; ren = 1'b1;
    #1 d = rdata;
    ren = 1'b0;
  endtask

  // Bits listed in transmission order, leftmost first
  task automatic push_seq(input logic [7:0] bits);
    for (int i = 7; i >= 0; i--) exp_q.push_back(bits[i]);
  endtask

  task automatic wait_strobes(input int target, input string name);
    int n = 0;
    while (strobe_cnt < target && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(strobe_cnt >= target), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst) begin
      hold = 0;
      prev_busy = 1'b0;
    end else begin
      if (bit_strobe) begin
        strobe_cnt++;
        if (prev_busy) chk("strobe_period", 32'(hold + 1), 32'(CODE_LEN));
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", 32'd1, 32'd0);
        end else begin
          cur_bit = exp_q.pop_front();
          chk("bit_value", 32'(data_out), 32'(cur_bit));
        end
        chk("busy_on_strobe", 32'(busy), 32'd1);
        hold = 0;
      end else if (busy) begin
        hold++;
        chk("bit_hold", 32'(data_out), 32'(cur_bit));
      end else begin
        hold = 0;
      end
      prev_busy = busy;
    end
  end

  initial begin
    logic [31:0] d;
    int cnt;
    int base;
    rst = 1'b1; wen = 1'b0; ren = 1'b0; wstrb = 4'd0;
    waddr = '0; wdata = '0; raddr = '0;
    repeat (3) @(negedge clk);
    chk("rst_data_out", 32'(data_out), 32'(IDLE_BIT));
    chk("rst_strobe", 32'(bit_strobe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_irq", 32'(irq_empty), 32'd0);
    rst = 1'b0;
    rd(8'h08, d); chk("rst_status", d, 32'h001);
    rd(8'h00, d); chk("rst_ctrl", d, 32'h0);
    raddr = 32'h8; ren = 1'b0; #1 chk("rdata_ren0", rdata, 32'h0);

    // Single byte LSB-first
    wr(8'h00, 32'h1, 4'h1);
    base = strobe_cnt;
    push_seq(8'b1010_0101);
    wr(8'h04, 32'hA5, 4'h1);
    @(negedge clk);
    chk("first_bit_busy", 32'(busy), 32'd1);
    chk("first_bit_strobe", 32'(bit_strobe), 32'd1);
    cnt = 0;
    while (busy && cnt < 1000) begin cnt++; @(negedge clk); end
    chk("single_busy_len", 32'(cnt), 32'd48);
    chk("single_strobes", 32'(strobe_cnt - base), 32'd8);
    chk("single_idle_bit", 32'(data_out), 32'(IDLE_BIT));
    chk("single_irq", 32'(irq_empty), 32'd1);

    // MSB-first back-to-back
    wr(8'h00, 32'h4, 4'h1);
    push_seq(8'b1000_0001);
    push_seq(8'b0011_1100);
    wr(8'h04, 32'h81, 4'h1);
    wr(8'h04, 32'h3C, 4'h1);
    wr(8'h00, 32'h5, 4'h1);
    cnt = 0;
    while (!busy && cnt < 20) begin cnt++; @(negedge clk); end
    cnt = 0;
    while (busy && cnt < 1000) begin cnt++; @(negedge clk); end
    chk("b2b_busy_len", 32'(cnt), 32'd96);
    chk("b2b_queue_drained", 32'(exp_q.size()), 32'd0);

    // Overflow
    wr(8'h00, 32'h0, 4'h1);
    for (int i = 0; i < 9; i++) wr(8'h04, 32'(8'h10 + i), 4'h1);
    rd(8'h08, d); chk("ovf_status", d, 32'h182);
    wr(8'h08, 32'h100, 4'h2);
    rd(8'h08, d); chk("ovf_cleared", d, 32'h082);
    wr(8'h04, 32'h99, 4'h1);
    rd(8'h08, d); chk("ovf_again", d, 32'h182);
    wr(8'h00, 32'h2, 4'h1);
    rd(8'h08, d); chk("flush_keeps_ovf", d, 32'h101);
    wr(8'h08, 32'h100, 4'h2);
    rd(8'h08, d); chk("ovf_clear2", d, 32'h001);
    rd(8'h04, d); chk("data_reads_0", d, 32'h0);
    rd(8'h0C, d); chk("unmapped_0", d, 32'h0);

    // Enable dropped during bit 3 of first byte
    wr(8'h00, 32'h1, 4'h1);
    base = strobe_cnt;
    push_seq(8'b1111_1111);
    wr(8'h04, 32'hFF, 4'h1);
    wr(8'h04, 32'h00, 4'h1);
    wait_strobes(base + 4, "en_drop_wait");
    wr(8'h00, 32'h0, 4'h1);
    wait_idle("en_drop_done");
    chk("en_drop_idle_bit", 32'(data_out), 32'(IDLE_BIT));
    chk("en_drop_strobes", 32'(strobe_cnt - base), 32'd8);
    rd(8'h08, d); chk("en_drop_status", d, 32'h010);
    chk("en_drop_irq", 32'(irq_empty), 32'd0);
    repeat (20) @(negedge clk);
    chk("en_drop_no_more", 32'(strobe_cnt - base), 32'd8);
    wr(8'h00, 32'h2, 4'h1);

    // Flush during bit 5 with bytes queued
    wr(8'h00, 32'h1, 4'h1);
    base = strobe_cnt;
    push_seq(8'b0100_1000);
    wr(8'h04, 32'h12, 4'h1);
    wr(8'h04, 32'h34, 4'h1);
    wr(8'h04, 32'h56, 4'h1);
    wait_strobes(base + 6, "flush_wait");
    wr(8'h00, 32'h3, 4'h1);
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_idle_bit", 32'(data_out), 32'(IDLE_BIT));
    exp_q.delete();
    rd(8'h08, d); chk("flush_status", d, 32'h001);
    rd(8'h00, d); chk("flush_ctrl", d, 32'h1);
    chk("flush_irq", 32'(irq_empty), 32'd1);
    repeat (20) @(negedge clk);
    chk("flush_no_more", 32'(strobe_cnt - base), 32'd6);

    // Reset mid-byte
    base = strobe_cnt;
    push_seq(8'b1100_0011);
    wr(8'h04, 32'hC3, 4'h1);
    wait_strobes(base + 3, "rst_mid_wait");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstm_data_out", 32'(data_out), 32'(IDLE_BIT));
    chk("rstm_strobe", 32'(bit_strobe), 32'd0);
    chk("rstm_busy", 32'(busy), 32'd0);
    chk("rstm_irq", 32'(irq_empty), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    base = strobe_cnt;
    repeat (30) @(negedge clk);
    chk("rstm_no_strobe", 32'(strobe_cnt - base), 32'd0);
    rd(8'h00, d); chk("rstm_ctrl", d, 32'h0);
    rd(8'h08, d); chk("rstm_status", d, 32'h001);
    wr(8'h00, 32'h1, 4'h1);
    push_seq(8'b0101_1010);
    wr(8'h04, 32'h5A, 4'h1);
    @(negedge clk);
    wait_idle("rstm_resume_done");
    chk("rstm_resume_strobes", 32'(strobe_cnt - base), 32'd8);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
